// File: rtl/game_flow_controller.sv
// game_flow_controller: space invaders game sequencer.
// Runs the IDLE/INTRO/PLAY/DEATH/CLEAR/OVER/WIN flow
// and keeps lives, level and score.
// Inputs : clk, rst (sync, active-high), startOfFrame,
//          keyCode/make, player_hit, monster_killed,
//          monsters_cleared, invaders_landed.
// Outputs: game_state, game_active, level_restart,
//          player_respawn, level, lives, score
//          (all registered).
module game_flow_controller #(
    parameter int               KEYCODE_WIDTH = 9,
    parameter logic [KEYCODE_WIDTH-1:0] START_KEY = 9'h029,
    parameter int               LIVES         = 3,
    parameter int               NUM_LEVELS    = 4,
    parameter int               INTRO_FRAMES  = 120,
    parameter int               DEATH_FRAMES  = 90,
    parameter int               CLEAR_FRAMES  = 60,
    parameter int               KILL_POINTS   = 10,
    parameter int               SCORE_WIDTH   = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     startOfFrame,
    input  logic [KEYCODE_WIDTH-1:0] keyCode,
    input  logic                     make,
    input  logic                     player_hit,
    input  logic                     monster_killed,
    input  logic                     monsters_cleared,
    input  logic                     invaders_landed,
    output logic [2:0]               game_state,
    output logic                     game_active,
    output logic                     level_restart,
    output logic                     player_respawn,
    output logic [1:0]               level,
    output logic [1:0]               lives,
    output logic [SCORE_WIDTH-1:0]   score
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_INTRO = 3'd1,
        S_PLAY  = 3'd2,
        S_DEATH = 3'd3,
        S_CLEAR = 3'd4,
        S_OVER  = 3'd5,
        S_WIN   = 3'd6
    } state_t;

    localparam int FW = 16;
    localparam int AW = SCORE_WIDTH + 16;

    state_t                 state_q, state_d;
    logic [FW-1:0]          frame_cnt_q, frame_cnt_d;
    logic [1:0]             lives_q, lives_d;
    logic [1:0]             level_q, level_d;
    logic [SCORE_WIDTH-1:0] score_q, score_d;
    logic                   active_q, active_d;
    logic                   restart_q, restart_d;
    logic                   respawn_q, respawn_d;

    logic          key_press;
    logic [FW-1:0] frame_next;
    logic [AW-1:0] lvl_mult;
    logic [AW-1:0] score_sum;
    logic [AW-1:0] score_max;

    assign key_press  = make && (keyCode == START_KEY);
    assign frame_next = frame_cnt_q + 1'b1;

    // Wide sum so the saturation test cannot be fooled by a wrap.
    assign lvl_mult  = AW'(level_q) + AW'(1);
    assign score_sum = AW'(score_q) + AW'(KILL_POINTS) * lvl_mult;
    assign score_max = AW'({SCORE_WIDTH{1'b1}});

    always_comb begin
        state_d     = state_q;
        frame_cnt_d = startOfFrame ? frame_next : frame_cnt_q;
        lives_d     = lives_q;
        level_d     = level_q;
        score_d     = score_q;
        restart_d   = 1'b0;
        respawn_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (key_press) begin
                    state_d   = S_INTRO;
                    lives_d   = 2'(LIVES);
                    level_d   = 2'd0;
                    score_d   = '0;
                    restart_d = 1'b1;
                    respawn_d = 1'b1;
                end
            end
            S_INTRO: begin
                if (startOfFrame && frame_next == FW'(INTRO_FRAMES))
                    state_d = S_PLAY;
            end
            S_PLAY: begin
                if (monster_killed) begin
                    if (score_sum > score_max)
                        score_d = {SCORE_WIDTH{1'b1}};
                    else
                        score_d = score_sum[SCORE_WIDTH-1:0];
                end
                if (invaders_landed) begin
                    state_d = S_OVER;
                    lives_d = 2'd0;
                end else if (player_hit) begin
                    if (lives_q <= 2'd1) begin
                        state_d = S_OVER;
                        lives_d = 2'd0;
                    end else begin
                        state_d = S_DEATH;
                        lives_d = lives_q - 2'd1;
                    end
                end else if (monsters_cleared) begin
                    state_d = S_CLEAR;
                end
            end
            S_DEATH: begin
                if (startOfFrame && frame_next == FW'(DEATH_FRAMES)) begin
                    state_d   = S_PLAY;
                    respawn_d = 1'b1;
                end
            end
            S_CLEAR: begin
                if (startOfFrame && frame_next == FW'(CLEAR_FRAMES)) begin
                    if (level_q == 2'(NUM_LEVELS - 1)) begin
                        state_d = S_WIN;
                    end else begin
                        state_d   = S_INTRO;
                        level_d   = level_q + 2'd1;
                        restart_d = 1'b1;
                        respawn_d = 1'b1;
                    end
                end
            end
            S_OVER, S_WIN: begin
                // Results stay on screen until the player acknowledges.
                if (key_press) begin
                    state_d = S_IDLE;
                    lives_d = 2'd0;
                    level_d = 2'd0;
                    score_d = '0;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d != state_q)
            frame_cnt_d = '0;
        active_d = (state_d == S_PLAY);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            frame_cnt_q <= '0;
            lives_q     <= 2'd0;
            level_q     <= 2'd0;
            score_q     <= '0;
            active_q    <= 1'b0;
            restart_q   <= 1'b0;
            respawn_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            frame_cnt_q <= frame_cnt_d;
            lives_q     <= lives_d;
            level_q     <= level_d;
            score_q     <= score_d;
            active_q    <= active_d;
            restart_q   <= restart_d;
            respawn_q   <= respawn_d;
        end
    end

    assign game_state     = state_q;
    assign game_active    = active_q;
    assign level_restart  = restart_q;
    assign player_respawn = respawn_q;
    assign level          = level_q;
    assign lives          = lives_q;
    assign score          = score_q;

endmodule
